// File: rtl/serial_adc_frame_decoder_pkg.sv
// serial_adc_pkg
//   Shared definitions for the serial ADC frame decoder: parameter limits,
//   the frame FSM state type and the bit-insert helper used by every lane
//   shift register.
package serial_adc_pkg;

  localparam int unsigned MAX_CH    = 8;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned MAX_W     = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } fsm_state_e;

  // Shift one serial bit into a word of 'width' valid bits held in the low
  // bits of 'cur'. MSB-first shifts left with the new bit at bit 0, so the
  // first bit ends at the MSB. LSB-first shifts right with the new bit at
  // bit width-1, so the first bit ends at bit 0. Bits above 'width' are
  // don't-care and are dropped by the caller.
  function automatic logic [MAX_W-1:0] insert_bit(
    input logic [MAX_W-1:0] cur,
    input logic             bit_in,
    input logic             msb_first,
    input int unsigned      width
  );
    logic [MAX_W-1:0] res;
    if (msb_first) begin
      res = {cur[MAX_W-2:0], bit_in};
    end else begin
      res = (cur >> 1) | (MAX_W'(bit_in) << (width - 1));
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_adc_frame_decoder_sync_edge_det.sv
// sync_edge_det
//   Multi-stage synchroniser for asynchronous pins with edge detection on
//   the synchronised level. Every bit gets an identical chain so lanes that
//   share a clock pin stay aligned with it.
// Ports
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset, clears the chain to 0
//   async_i  in   WIDTH asynchronous inputs
//   level_o  out  synchronised level (last chain stage)
//   rise_o   out  level is 1 and was 0 one cycle earlier
//   fall_o   out  level is 0 and was 1 one cycle earlier
module sync_edge_det #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] dly_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      dly_q <= '0;
    end else begin
      chain_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      dly_q <= chain_q[STAGES-1];
    end
  end

  assign level_o = chain_q[STAGES-1];
  assign rise_o  = chain_q[STAGES-1] & ~dly_q;
  assign fall_o  = ~chain_q[STAGES-1] & dly_q;

endmodule

// File: rtl/serial_adc_frame_decoder.sv
// serial_adc_frame_decoder
//   Multi-lane deserialiser for serial-output ADCs. DCLK, the frame enable
//   NVM and the SDO lanes are oversampled on clock_system; one bit per lane
//   is shifted on each synchronised DCLK falling edge inside a frame, and
//   complete words are published for all lanes at once.
//
//   state | meaning
//   IDLE  | no frame; waiting for a clean nvm rising edge
//   ARMED | frame active; DCLK falls shift bits, words are published
//
// Ports
//   clock_system  in   system clock
//   rst           in   asynchronous active-high reset
//   dclk          in   ADC serial clock (async)
//   nvm           in   ADC frame enable, high = frame active (async)
//   sdo           in   NUM_CH serial data lanes (async)
//   stat_clr      in   clears sample_count and overrun_err
//   data_out      out  last complete words, lane k at [k*DATA_W +: DATA_W]
//   data_valid    out  one-cycle pulse, data_out updated in the same cycle
//   word_idx      out  index of the published word within its frame
//   sample_count  out  completed words since reset/clear, wraps
//   frame_err     out  one-cycle pulse: frame ended inside a word
//   overrun_err   out  sticky: DCLK edge after the last expected word
module serial_adc_frame_decoder
  import serial_adc_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned WORDS_PER_FRAME = 1,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MSB_FIRST       = 1
) (
  input  logic                     clock_system,
  input  logic                     rst,
  input  logic                     dclk,
  input  logic                     nvm,
  input  logic [NUM_CH-1:0]        sdo,
  input  logic                     stat_clr,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     data_valid,
  output logic [3:0]               word_idx,
  output logic [CNT_W-1:0]         sample_count,
  output logic                     frame_err,
  output logic                     overrun_err
);

  localparam int unsigned BCW = $clog2(DATA_W);
  localparam int unsigned WCW = $clog2(MAX_WORDS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic [WCW-1:0] WORDS_C  = WCW'(WORDS_PER_FRAME);

  logic              dclk_s, dclk_fall, dclk_rise_unused;
  logic              nvm_s, nvm_rise, nvm_fall_unused;
  logic [NUM_CH-1:0] sdo_s, sdo_rise_unused, sdo_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_dclk (
    .clk_i   (clock_system),
    .rst_i   (rst),
    .async_i (dclk),
    .level_o (dclk_s),
    .rise_o  (dclk_rise_unused),
    .fall_o  (dclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_nvm (
    .clk_i   (clock_system),
    .rst_i   (rst),
    .async_i (nvm),
    .level_o (nvm_s),
    .rise_o  (nvm_rise),
    .fall_o  (nvm_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .WIDTH(NUM_CH)) u_sync_sdo (
    .clk_i   (clock_system),
    .rst_i   (rst),
    .async_i (sdo),
    .level_o (sdo_s),
    .rise_o  (sdo_rise_unused),
    .fall_o  (sdo_fall_unused)
  );

  fsm_state_e              state_q;
  logic [BCW-1:0]          bit_cnt_q;
  logic [WCW-1:0]          word_cnt_q;
  logic [NUM_CH*DATA_W-1:0] data_out_q;
  logic                    data_valid_q;
  logic [3:0]              word_idx_q;
  logic [CNT_W-1:0]        sample_count_q;
  logic                    frame_err_q;
  logic                    overrun_q;
  // Fills with ones after reset; its top bit marks the point where the nvm
  // edge detector compares two real pin samples. Until then the chain is
  // still flushing its reset zeros, and a "rise" would only mean nvm was
  // already high when reset was released, i.e. a frame already in progress.
  logic [SYNC_STAGES:0]    warm_q;

  logic                     shift_en;
  logic [NUM_CH*DATA_W-1:0] shift_d;

  // Frame end wins over a coincident DCLK fall, and nothing shifts once all
  // words of the frame have been collected.
  assign shift_en = (state_q == ARMED) && nvm_s && dclk_fall && (word_cnt_q != WORDS_C);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [DATA_W-1:0] lane_q;

    assign shift_d[k*DATA_W +: DATA_W] =
      DATA_W'(insert_bit(MAX_W'(lane_q), sdo_s[k], MSB_FIRST != 0, DATA_W));

    always_ff @(posedge clock_system or posedge rst) begin
      if (rst) begin
        lane_q <= '0;
      end else if (shift_en) begin
        lane_q <= shift_d[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock_system or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      word_idx_q     <= '0;
      sample_count_q <= '0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
      warm_q         <= '0;
    end else begin
      warm_q       <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // A word completing in the same cycle overrides the clear below with 1,
      // and an overrun in the same cycle overrides it with 1.
      if (stat_clr) begin
        sample_count_q <= '0;
        overrun_q      <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          bit_cnt_q  <= '0;
          word_cnt_q <= '0;
          if (nvm_rise && warm_q[SYNC_STAGES]) state_q <= ARMED;
        end

        ARMED: begin
          if (!nvm_s) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            if (bit_cnt_q != '0) frame_err_q <= 1'b1;
          end else if (dclk_fall) begin
            if (word_cnt_q == WORDS_C) begin
              overrun_q <= 1'b1;
            end else if (bit_cnt_q == LAST_BIT) begin
              // Publish straight from the shift path so the last bit lands
              // in data_out on the same edge it is sampled.
              data_out_q     <= shift_d;
              data_valid_q   <= 1'b1;
              word_idx_q     <= word_cnt_q[3:0];
              sample_count_q <= stat_clr ? CNT_W'(1) : sample_count_q + CNT_W'(1);
              bit_cnt_q      <= '0;
              word_cnt_q     <= word_cnt_q + 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign word_idx     = word_idx_q;
  assign sample_count = sample_count_q;
  assign frame_err    = frame_err_q;
  assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_serial_adc_frame_decoder.sv
// Testbench for serial_adc_frame_decoder. Four instances share the same pins:
// default parameters, LSB-first, two words per frame, and a 4-bit counter.
module tb_serial_adc_frame_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dclk = 1'b0;
  logic       nvm = 1'b0;
  logic       stat_clr = 1'b0;
  logic [1:0] sdo = 2'b00;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_fall_cyc = 0;
  int exp_cnt = 0;
  int dv_cnt_def = 0;
  int fe_cnt_def = 0;

  logic [31:0] do_def, do_lsb, do_wpf2, do_cnt4;
  logic        dv_def, dv_lsb, dv_wpf2, dv_cnt4;
  logic [3:0]  wi_def, wi_lsb, wi_wpf2, wi_cnt4;
  logic [17:0] sc_def, sc_lsb, sc_wpf2;
  logic [3:0]  sc_cnt4;
  logic        fe_def, fe_lsb, fe_wpf2, fe_cnt4;
  logic        ov_def, ov_lsb, ov_wpf2, ov_cnt4;

  serial_adc_frame_decoder u_def (
    .clock_system(clk), .rst(rst), .dclk(dclk), .nvm(nvm), .sdo(sdo), .stat_clr(stat_clr),
    .data_out(do_def), .data_valid(dv_def), .word_idx(wi_def), .sample_count(sc_def),
    .frame_err(fe_def), .overrun_err(ov_def));

  serial_adc_frame_decoder #(.MSB_FIRST(0)) u_lsb (
    .clock_system(clk), .rst(rst), .dclk(dclk), .nvm(nvm), .sdo(sdo), .stat_clr(stat_clr),
    .data_out(do_lsb), .data_valid(dv_lsb), .word_idx(wi_lsb), .sample_count(sc_lsb),
    .frame_err(fe_lsb), .overrun_err(ov_lsb));

  serial_adc_frame_decoder #(.WORDS_PER_FRAME(2)) u_wpf2 (
    .clock_system(clk), .rst(rst), .dclk(dclk), .nvm(nvm), .sdo(sdo), .stat_clr(stat_clr),
    .data_out(do_wpf2), .data_valid(dv_wpf2), .word_idx(wi_wpf2), .sample_count(sc_wpf2),
    .frame_err(fe_wpf2), .overrun_err(ov_wpf2));

  serial_adc_frame_decoder #(.CNT_W(4)) u_cnt4 (
    .clock_system(clk), .rst(rst), .dclk(dclk), .nvm(nvm), .sdo(sdo), .stat_clr(stat_clr),
    .data_out(do_cnt4), .data_valid(dv_cnt4), .word_idx(wi_cnt4), .sample_count(sc_cnt4),
    .frame_err(fe_cnt4), .overrun_err(ov_cnt4));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic [17:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] wpf2_idx_q[$];

  // Scoreboard for the default instance: every data_valid pops one expected
  // word; latency is measured from the last pin DCLK fall.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (fe_def) fe_cnt_def++;
    if (dv_wpf2) wpf2_idx_q.push_back(wi_wpf2);
    if (dv_def) begin
      dv_cnt_def++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_valid data_out=%h expected no word", do_def);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (do_def !== e.data) begin
          errors++; $display("FAIL sb_data got %h exp %h", do_def, e.data);
        end
        checks++;
        if (wi_def !== e.idx) begin
          errors++; $display("FAIL sb_word_idx got %0d exp %0d", wi_def, e.idx);
        end
        checks++;
        if (sc_def !== e.cnt) begin
          errors++; $display("FAIL sb_sample_count got %0d exp %0d", sc_def, e.cnt);
        end
        checks++;
        if ((cyc - last_fall_cyc) != 3) begin
          errors++; $display("FAIL sb_latency got %0d exp 3", cyc - last_fall_cyc);
        end
      end
    end
  end

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic [3:0] idx);
    exp_t e;
    exp_cnt++;
    e.data = d; e.idx = idx; e.cnt = 18'(exp_cnt);
    sb_q.push_back(e);
  endtask

  // One DCLK period; sdo changes with the rising edge and is stable at the fall.
  task automatic dclk_bit(input logic [1:0] b, input bit clr_at_publish);
    @(negedge clk);
    sdo = b; dclk = 1'b1;
    repeat (4) @(negedge clk);
    dclk = 1'b0; last_fall_cyc = cyc;
    if (clr_at_publish) begin
      repeat (2) @(posedge clk);
      @(negedge clk); stat_clr = 1'b1;
      @(negedge clk); stat_clr = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [15:0] l0, input logic [15:0] l1, input bit clr_last);
    for (int i = 15; i >= 0; i--) dclk_bit({l1[i], l0[i]}, clr_last && (i == 0));
  endtask

  task automatic nvm_up();
    @(negedge clk); nvm = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic nvm_down();
    @(negedge clk); nvm = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (do_def !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h exp 0", do_def); end
    checks++; if (dv_def !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b exp 0", dv_def); end
    checks++; if (wi_def !== 4'h0) begin errors++; $display("FAIL reset_word_idx got %0d exp 0", wi_def); end
    checks++; if (sc_def !== 18'h0) begin errors++; $display("FAIL reset_sample_count got %0d exp 0", sc_def); end
    checks++; if (fe_def !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", fe_def); end
    checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", ov_def); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    nvm_up();
    push_exp(32'h1234_A5C3, 4'd0);
    send_word(16'hA5C3, 16'h1234, 1'b0);
    nvm_down();
    checks++; if (sc_def !== 18'd1) begin errors++; $display("FAIL basic_sample_count got %0d exp 1", sc_def); end
    checks++; if (dv_cnt_def != 1) begin errors++; $display("FAIL basic_valid_count got %0d exp 1", dv_cnt_def); end
    checks++; if (do_lsb !== {rev16(16'h1234), rev16(16'hA5C3)}) begin
      errors++; $display("FAIL basic_lsb_data got %h exp %h", do_lsb, {rev16(16'h1234), rev16(16'hA5C3)});
    end
  endtask

  task automatic test_lsb_first();
    nvm_up();
    push_exp(32'h0000_8000, 4'd0);
    send_word(16'h8000, 16'h0000, 1'b0);
    nvm_down();
    checks++; if (do_lsb[15:0] !== 16'h0001) begin errors++; $display("FAIL lsb_lane0 got %h exp 0001", do_lsb[15:0]); end
    checks++; if (do_lsb[31:16] !== 16'h0000) begin errors++; $display("FAIL lsb_lane1 got %h exp 0000", do_lsb[31:16]); end
  endtask

  task automatic test_frame_err();
    logic [15:0] pat;
    int fe_before;
    pat = 16'h5555;
    fe_before = fe_cnt_def;
    nvm_up();
    for (int i = 15; i >= 7; i--) dclk_bit({pat[i], pat[i]}, 1'b0);
    nvm_down();
    checks++; if (fe_cnt_def != fe_before + 1) begin errors++; $display("FAIL frame_err_pulses got %0d exp %0d", fe_cnt_def - fe_before, 1); end
    checks++; if (do_def !== 32'h0000_8000) begin errors++; $display("FAIL frame_err_data_kept got %h exp 00008000", do_def); end
    checks++; if (sc_def !== 18'd2) begin errors++; $display("FAIL frame_err_count got %0d exp 2", sc_def); end
    nvm_up();
    push_exp(32'h0F0F_BEEF, 4'd0);
    send_word(16'hBEEF, 16'h0F0F, 1'b0);
    nvm_down();
    checks++; if (do_def !== 32'h0F0F_BEEF) begin errors++; $display("FAIL frame_err_next_frame got %h exp 0f0fbeef", do_def); end
  endtask

  task automatic test_overrun();
    wpf2_idx_q.delete();
    nvm_up();
    push_exp(32'h0123_CAFE, 4'd0);
    send_word(16'hCAFE, 16'h0123, 1'b0);
    send_word(16'h5A5A, 16'hF00D, 1'b0);
    dclk_bit(2'b11, 1'b0);
    dclk_bit(2'b11, 1'b0);
    nvm_down();
    checks++; if (wpf2_idx_q.size() != 2) begin errors++; $display("FAIL overrun_wpf2_words got %0d exp 2", wpf2_idx_q.size()); end
    if (wpf2_idx_q.size() >= 2) begin
      checks++; if (wpf2_idx_q[0] !== 4'd0) begin errors++; $display("FAIL overrun_idx0 got %0d exp 0", wpf2_idx_q[0]); end
      checks++; if (wpf2_idx_q[1] !== 4'd1) begin errors++; $display("FAIL overrun_idx1 got %0d exp 1", wpf2_idx_q[1]); end
    end
    checks++; if (do_wpf2 !== 32'hF00D_5A5A) begin errors++; $display("FAIL overrun_wpf2_data got %h exp f00d5a5a", do_wpf2); end
    checks++; if (sc_wpf2 !== 18'd5) begin errors++; $display("FAIL overrun_wpf2_count got %0d exp 5", sc_wpf2); end
    checks++; if (ov_wpf2 !== 1'b1) begin errors++; $display("FAIL overrun_wpf2_flag got %b exp 1", ov_wpf2); end
    checks++; if (ov_def !== 1'b1) begin errors++; $display("FAIL overrun_def_flag got %b exp 1", ov_def); end
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    exp_cnt = 0;
    checks++; if (ov_wpf2 !== 1'b0) begin errors++; $display("FAIL stat_clr_overrun got %b exp 0", ov_wpf2); end
    checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL stat_clr_overrun_def got %b exp 0", ov_def); end
    checks++; if (sc_def !== 18'd0) begin errors++; $display("FAIL stat_clr_count got %0d exp 0", sc_def); end
  endtask

  task automatic test_reset_midframe();
    int dv_before;
    nvm_up();
    push_exp(32'h3C3C_7E81, 4'd0);
    send_word(16'h7E81, 16'h3C3C, 1'b0);
    for (int i = 0; i < 5; i++) dclk_bit(2'b01, 1'b0);
    checks++; if (ov_def !== 1'b1) begin errors++; $display("FAIL midrst_pre_overrun got %b exp 1", ov_def); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (do_def !== 32'h0) begin errors++; $display("FAIL midrst_data_out got %h exp 0", do_def); end
    checks++; if (sc_def !== 18'h0) begin errors++; $display("FAIL midrst_count got %0d exp 0", sc_def); end
    checks++; if (ov_def !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b exp 0", ov_def); end
    checks++; if (do_wpf2 !== 32'h0) begin errors++; $display("FAIL midrst_wpf2_data got %h exp 0", do_wpf2); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    dv_before = dv_cnt_def;
    send_word(16'hFFFF, 16'hFFFF, 1'b0);
    nvm_down();
    checks++; if (dv_cnt_def != dv_before) begin errors++; $display("FAIL midrst_ignored_frame got %0d words exp 0", dv_cnt_def - dv_before); end
    nvm_up();
    push_exp(32'hAAAA_5555, 4'd0);
    send_word(16'h5555, 16'hAAAA, 1'b0);
    nvm_down();
    checks++; if (sc_def !== 18'd1) begin errors++; $display("FAIL midrst_new_frame_count got %0d exp 1", sc_def); end
  endtask

  task automatic test_wrap();
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      nvm_up();
      push_exp({16'(i), 16'(i * 3 + 1)}, 4'd0);
      send_word(16'(i * 3 + 1), 16'(i), 1'b0);
      nvm_down();
    end
    checks++; if (sc_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got %0d exp 1", sc_cnt4); end
    checks++; if (sc_def !== 18'd17) begin errors++; $display("FAIL wrap_def_count got %0d exp 17", sc_def); end
    nvm_up();
    exp_cnt = 0;
    push_exp(32'h9999_6666, 4'd0);
    send_word(16'h6666, 16'h9999, 1'b1);
    nvm_down();
    checks++; if (sc_cnt4 !== 4'd1) begin errors++; $display("FAIL clr_with_valid_cnt4 got %0d exp 1", sc_cnt4); end
    checks++; if (sc_def !== 18'd1) begin errors++; $display("FAIL clr_with_valid_def got %0d exp 1", sc_def); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_wrap();
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_missing_words got %0d pending exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
